// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared types, constants and length clamp for spi_master
// Contents: spi_state_t FSM encoding, SPI_MIN_LEN/SPI_MAX_LEN/SPI_DATA_W, clamp_len().
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        GAP
    } spi_state_t;

    localparam int SPI_MIN_LEN = 2;
    localparam int SPI_MAX_LEN = 8;
    localparam int SPI_DATA_W  = 8;

    // Requested lengths outside 2..8 run at the nearest legal length.
    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (len < 4'(SPI_MIN_LEN)) begin
            return 4'(SPI_MIN_LEN);
        end else if (len > 4'(SPI_MAX_LEN)) begin
            return 4'(SPI_MAX_LEN);
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - two-flop synchronizer for a single asynchronous bit
// Ports: clk, rstb (async active-low, output resets to 0), d (async input), q (synchronized output).
module spi_sync2 (
    input  logic clk,
    input  logic rstb,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 initiator running one 2..8-bit full-duplex transfer per start
// Ports: clk, rstb (async active-low); start, xfer_len, wr_data (request, sampled on accept);
//        busy, done, rd_data (status and right-justified result);
//        spi_csb, spi_clk, spi_dout (bus outputs), spi_din (async slave data in).
module spi_master
    import spi_master_pkg::*;
#(
    parameter int HALF_DIV = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  start,
    input  logic [3:0]            xfer_len,
    input  logic [SPI_DATA_W-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [SPI_DATA_W-1:0] rd_data,
    output logic                  spi_csb,
    output logic                  spi_clk,
    output logic                  spi_dout,
    input  logic                  spi_din
);

    spi_state_t            state, state_nxt;
    logic [7:0]            cnt, cnt_nxt;
    logic [3:0]            bits_left, bits_nxt;
    logic [SPI_DATA_W-1:0] tx_shift, tx_nxt;
    logic [SPI_DATA_W-1:0] rx_shift, rx_nxt;
    logic                  din_sync;
    logic                  gap_entry;

    spi_sync2 u_din_sync (
        .clk  (clk),
        .rstb (rstb),
        .d    (spi_din),
        .q    (din_sync)
    );

    assign gap_entry = (state_nxt == GAP) && (state != GAP);
    assign spi_dout  = tx_shift[SPI_DATA_W-1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 8'd1;
        bits_nxt  = bits_left;
        tx_nxt    = tx_shift;
        rx_nxt    = rx_shift;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // cnt is 1 only in the first IDLE cycle after GAP; a start
                // landing in the cycle busy drops is deliberately not taken.
                if (start && (cnt == 8'd0)) begin
                    state_nxt = SETUP;
                    bits_nxt  = clamp_len(xfer_len);
                    tx_nxt    = wr_data;
                    rx_nxt    = '0;
                end
            end
            SETUP: begin
                if (cnt == 8'(CS_SETUP - 1)) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end
            end
            HIGH: begin
                if (cnt == 8'd0) begin
                    rx_nxt   = {rx_shift[SPI_DATA_W-2:0], din_sync};
                    bits_nxt = bits_left - 4'd1;
                end
                if (cnt == 8'(HALF_DIV - 1)) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    // bits_left already counts the bit just clocked; the last
                    // bit is left on spi_dout until the next accept.
                    if (bits_left != 4'd0) begin
                        tx_nxt = {tx_shift[SPI_DATA_W-2:0], 1'b0};
                    end
                end
            end
            LOW: begin
                if (cnt == 8'(HALF_DIV - 1)) begin
                    state_nxt = (bits_left != 4'd0) ? HIGH : GAP;
                    cnt_nxt   = '0;
                end
            end
            GAP: begin
                if (cnt == 8'(CS_IDLE - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Bus and status outputs are registered from the next state so they
    // change together with the FSM and never glitch.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            cnt       <= '0;
            bits_left <= '0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            rd_data   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            spi_csb   <= 1'b1;
            spi_clk   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bits_left <= bits_nxt;
            tx_shift  <= tx_nxt;
            rx_shift  <= rx_nxt;
            busy      <= (state_nxt != IDLE);
            spi_csb   <= !((state_nxt == SETUP) || (state_nxt == HIGH) || (state_nxt == LOW));
            spi_clk   <= (state_nxt == HIGH);
            done      <= gap_entry;
            if (gap_entry) begin
                rd_data <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master with a behavioural SPI slave
// Instances: dut8 (HALF_DIV=8) and dut4 (HALF_DIV=4), selected by sel onto one slave/monitor.
module tb_spi_master;

    localparam int CS_SETUP = 4;
    localparam int CS_IDLE  = 4;

    logic       clk = 1'b0;
    logic       rstb;
    logic       start;
    logic       sel;
    logic [3:0] xfer_len;
    logic [7:0] wr_data;
    logic       spi_din;

    logic       busy8, done8, csb8, sclk8, dout8;
    logic       busy4, done4, csb4, sclk4, dout4;
    logic [7:0] rd8, rd4;

    logic       busy, done, csb, sclk, dout;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_master #(.HALF_DIV(8), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)) dut8 (
        .clk(clk), .rstb(rstb), .start(start & ~sel), .xfer_len(xfer_len), .wr_data(wr_data),
        .busy(busy8), .done(done8), .rd_data(rd8),
        .spi_csb(csb8), .spi_clk(sclk8), .spi_dout(dout8), .spi_din(spi_din)
    );

    spi_master #(.HALF_DIV(4), .CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE)) dut4 (
        .clk(clk), .rstb(rstb), .start(start & sel), .xfer_len(xfer_len), .wr_data(wr_data),
        .busy(busy4), .done(done4), .rd_data(rd4),
        .spi_csb(csb4), .spi_clk(sclk4), .spi_dout(dout4), .spi_din(spi_din)
    );

    assign busy    = sel ? busy4 : busy8;
    assign done    = sel ? done4 : done8;
    assign csb     = sel ? csb4  : csb8;
    assign sclk    = sel ? sclk4 : sclk8;
    assign dout    = sel ? dout4 : dout8;
    assign rd_data = sel ? rd4   : rd8;

    // Slave: presents the low sl_n bits of sl_word MSB first, advancing
    // sl_delay clk after each rising spi_clk; records MOSI at each rise.
    logic [7:0] sl_word = 8'h00;
    int         sl_n = 2;
    int         sl_delay = 1;
    int         sl_idx = 0;
    int         sl_pend = 0;
    logic       prev_sclk = 1'b0;
    logic       prev_csb_s = 1'b1;
    logic [7:0] mosi_bits = 8'h00;
    int         pulse_cnt = 0;

    function automatic logic slave_bit(input logic [7:0] w, input int n, input int idx);
        logic [7:0] s;
        s = w >> (n - 1 - idx);
        return s[0];
    endfunction

    assign spi_din = (!csb && sl_idx < sl_n) ? slave_bit(sl_word, sl_n, sl_idx) : 1'b0;

    always @(posedge clk) begin
        prev_sclk  <= sclk;
        prev_csb_s <= csb;
        if (csb) begin
            sl_idx  <= 0;
            sl_pend <= 0;
        end else if (sclk && !prev_sclk) begin
            mosi_bits <= {mosi_bits[6:0], dout};
            pulse_cnt <= pulse_cnt + 1;
            if (sl_delay <= 1) sl_idx <= sl_idx + 1;
            else sl_pend <= sl_delay - 1;
        end else if (sl_pend > 0) begin
            sl_pend <= sl_pend - 1;
            if (sl_pend == 1) sl_idx <= sl_idx + 1;
        end
        if (!csb && prev_csb_s) begin
            mosi_bits <= 8'h00;
            pulse_cnt <= 0;
        end
    end

    typedef struct {
        logic [7:0] rd;
        logic [7:0] mosi;
        int         n;
        int         acc;
        int         hd;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at cycle %0d", nm, act, expv, cyc);
        end
    endtask

    function automatic int clamp_n(input int len);
        if (len < 2) return 2;
        if (len > 8) return 8;
        return len;
    endfunction

    // Monitor: pops an expectation on every done pulse; also checks busy
    // release timing and the chip-select idle gap before each frame.
    initial begin
        exp_t e;
        int   hcnt = 100;
        logic pb = 1'b0;
        logic pc = 1'b1;
        bit   bw = 1'b0;
        int   last_acc = 0;
        int   busy_end = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    chk("rd_data", int'(rd_data), int'(e.rd));
                    chk("mosi_bits", int'(mosi_bits), int'(e.mosi));
                    chk("sclk_pulses", pulse_cnt, e.n);
                    chk("done_latency", cyc - e.acc, CS_SETUP + 2 * e.hd * e.n);
                    chk("csb_high_at_done", int'(csb), 1);
                    bw       = 1'b1;
                    last_acc = e.acc;
                    busy_end = CS_SETUP + 2 * e.hd * e.n + CS_IDLE;
                end
            end
            if (pb && !busy && bw) begin
                chk("busy_fall_latency", cyc - last_acc, busy_end);
                bw = 1'b0;
            end
            if (csb) begin
                hcnt++;
            end else if (pc) begin
                checks++;
                if (hcnt < CS_IDLE) begin
                    errors++;
                    $display("FAIL csb_idle_gap actual=%0d required>=%0d", hcnt, CS_IDLE);
                end
                hcnt = 0;
            end
            pc = csb;
            pb = busy;
        end
    end

    task automatic issue(input int len, input logic [7:0] wd, input logic [7:0] sw, input bit push);
        exp_t e;
        int   n;
        n        = clamp_n(len);
        sl_word  = sw;
        sl_n     = n;
        start    = 1'b1;
        xfer_len = 4'(len);
        wr_data  = wd;
        @(posedge clk);
        @(negedge clk);
        e.acc    = cyc;
        e.n      = n;
        e.hd     = sel ? 4 : 8;
        e.mosi   = wd >> (8 - n);
        e.rd     = 8'(int'(sw) & ((1 << n) - 1));
        start    = 1'b0;
        xfer_len = 4'($urandom);
        wr_data  = 8'($urandom);
        if (push) q.push_back(e);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout busy=%0b expected=0", busy);
        end
        @(negedge clk);
    endtask

    task automatic xfer(input int len, input logic [7:0] wd, input logic [7:0] sw);
        wait_idle();
        issue(len, wd, sw, 1'b1);
    endtask

    initial begin
        int g;
        int dcnt;
        rstb     = 1'b0;
        start    = 1'b0;
        sel      = 1'b0;
        xfer_len = 4'd0;
        wr_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_csb", int'(csb8), 1);
        chk("reset_sclk", int'(sclk8), 0);
        chk("reset_dout", int'(dout8), 0);
        chk("reset_busy", int'(busy8), 0);
        chk("reset_done", int'(done8), 0);
        chk("reset_rd_data", int'(rd8), 0);
        chk("reset_csb_hd4", int'(csb4), 1);
        rstb = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        sl_delay = 2;
        xfer(8, 8'hA5, 8'h3C);
        xfer(3, 8'hC0, 8'h05);
        xfer(0, 8'($urandom), 8'($urandom));
        xfer(15, 8'($urandom), 8'($urandom));

        // Start mid-transfer and in the cycle busy drops: both ignored.
        wait_idle();
        issue(8, 8'h5A, 8'h96, 1'b1);
        repeat (8) @(negedge clk);
        start    = 1'b1;
        xfer_len = 4'd2;
        wr_data  = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (busy && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("busy_dropped", int'(busy), 0);
        start = 1'b1;
        @(negedge clk);
        chk("start_at_busy_fall_ignored", int'(busy), 0);
        issue(4, 8'($urandom), 8'($urandom), 1'b1);

        // Reset after three bits aborts the transfer without done.
        wait_idle();
        issue(8, 8'($urandom), 8'($urandom), 1'b0);
        @(negedge clk);
        g = 0;
        while (pulse_cnt < 3 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("abort_three_pulses", pulse_cnt, 3);
        #2 rstb = 1'b0;
        #1;
        chk("abort_csb", int'(csb), 1);
        chk("abort_sclk", int'(sclk), 0);
        chk("abort_busy", int'(busy), 0);
        @(negedge clk);
        rstb = 1'b1;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        xfer(8, 8'($urandom), 8'($urandom));

        repeat (12) begin
            wait_idle();
            sl_delay = int'($urandom_range(1, 4));
            issue(int'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 1'b1);
        end

        // HALF_DIV=4 instance with a slave that answers 4 clk after each rise.
        wait_idle();
        sel = 1'b1;
        repeat (4) @(negedge clk);
        sl_delay = 4;
        xfer(8, 8'hA5, 8'h3C);
        repeat (8) xfer(int'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));

        wait_idle();
        g = 0;
        while (q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI initiator that drives the shared SPI bus (chip select, clock and master-out data) toward the carrier's SPI slave interface, and captures the slave's returned data.
- It sits on the host/controller side of the bus.
- A single start request runs one 2..8-bit full-duplex transfer, MSB first, mode 0 (CPOL=0, data captured on the rising edge).
- Timing is sized so a slave that oversamples the bus with its own synchronizers sees clean edges and a valid chip-select frame.

Parameters:
HALF_DIV, 8, clk cycles per spi_clk half period; legal range 4..255.
CS_SETUP, 4, clk cycles from spi_csb low to the first spi_clk rising edge; legal range 4..255.
CS_IDLE, 4, minimum clk cycles spi_csb stays high between transfers; legal range 4..255.

Ports:
clk  in  1  system clock; single clock domain.
rstb  in  1  asynchronous active-low reset.
start  in  1  one-cycle transfer request; accepted only when busy=0.
xfer_len  in  4  transfer length in bits, sampled when start is accepted.
wr_data  in  8  transmit data, MSB-aligned, sampled when start is accepted.
busy  out  1  high from the cycle after start is accepted until the end of the CS_IDLE gap.
done  out  1  one-cycle pulse when rd_data is updated.
rd_data  out  8  received data, right-justified, MSBs zero-padded.
spi_csb  out  1  chip select, active low.
spi_clk  out  1  SPI clock; idles low.
spi_dout  out  1  master-out data, driven to the slave data input.
spi_din  in  1  master-in data from the slave output; asynchronous to clk.

Behaviour:
- Reset values: spi_csb=1, spi_clk=0, spi_dout=0, busy=0, done=0, rd_data=0, FSM in IDLE, all counters at 0.
- Reset asserted mid-transfer aborts immediately. The bus returns to idle levels asynchronously; no done pulse is generated.
- Length handling: N = clamp(xfer_len, 2, 8). Values 0 and 1 run as 2 bits; values 9..15 run as 8 bits.
- Transmit order: wr_data[7] first, down to wr_data[8-N].
- Receive: bits are shifted in MSB-first; rd_data = {zeros, N received bits}.
- spi_din passes through a 2-flop synchronizer before use.
- FSM states: IDLE, SETUP, HIGH, LOW, GAP.
  - IDLE: if start=1 in cycle T, latch wr_data into the shift register and N into the bit counter. From T+1: busy=1, spi_csb=0, spi_dout=wr_data[7]. Go to SETUP.
  - SETUP: lasts CS_SETUP cycles (T+1..T+CS_SETUP), then HIGH.
  - HIGH: spi_clk=1 for HALF_DIV cycles. On the entry cycle, capture the synchronized spi_din into the receive shifter. Then go to LOW.
  - LOW: spi_clk=0 for HALF_DIV cycles. On the entry cycle, if bits remain, spi_dout advances to the next bit. At the end of LOW: go to HIGH if bits remain, otherwise go to GAP.
  - GAP: on the entry cycle, spi_csb=1, rd_data is loaded and done=1 for one cycle. Stay CS_IDLE cycles, then IDLE with busy=0.
- Timing relative to accept cycle T:
  - First rising edge of spi_clk at T+CS_SETUP+1.
  - spi_csb rises and done pulses at T+CS_SETUP+2*HALF_DIV*N+1.
  - busy falls at T+CS_SETUP+2*HALF_DIV*N+CS_IDLE+1.
- spi_dout changes only in LOW entry cycles or at accept. It is stable across every rising edge.
- After the last bit, spi_dout holds its value until the next accept.
- Sampling margin: the slave updates its output within about 4 clk of a rising edge. The master samples 2*HALF_DIV clk later through its 2-flop synchronizer, so HALF_DIV>=4 guarantees correct data.
- start while busy=1 is ignored and not queued. start in the same cycle busy falls is also ignored; the next cycle with busy=0 accepts.
- wr_data and xfer_len changing during a transfer have no effect.

Decomposition:
- Package spi_master_pkg holds:
  - the FSM state enum: IDLE, SETUP, HIGH, LOW, GAP;
  - constants SPI_MIN_LEN=2, SPI_MAX_LEN=8, SPI_DATA_W=8;
  - a length-clamp function.
- One sub-module, spi_sync2: a 2-flop synchronizer with asynchronous active-low reset (reset value 0), used for spi_din.
- The divider counter, bit counter and shifters stay in spi_master.

Test Plan:
- Defaults, xfer_len=8, wr_data=0xA5, slave model returns 0x3C: MOSI bits sampled at rising edges are 1,0,1,0,0,1,0,1. rd_data=0x3C. spi_csb low for 4+128 cycles, done at T+133, busy falls at T+137.
- xfer_len=3, wr_data=0xC0, slave returns bits 1,0,1: MOSI is 1,1,0; rd_data=0x05; exactly 3 spi_clk pulses.
- xfer_len=0 and xfer_len=15: 2 and 8 spi_clk pulses respectively.
- start pulsed at T+10 during a transfer and again in the cycle busy falls: neither is accepted. A start one cycle later is accepted, and spi_csb has stayed high for at least CS_IDLE cycles.
- rstb pulsed low mid-transfer after 3 bits: spi_csb=1, spi_clk=0, busy=0 immediately, no done pulse. The next transfer completes correctly.
- HALF_DIV=4, slave model delays its output 4 clk after each rising edge: rd_data still matches the slave's transmitted byte.
